// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read-side master: skid buffer absorbing read latency, burst-framed valid/ready stream
module fifo_reader #(
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 4,
  parameter int SKID_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              read_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic [15:0]       rd_count
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(SKID_DEPTH - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid [SKID_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              inflight;
  logic [BW-1:0]     beat;
  logic              xfer;
  logic [CW:0]       load;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign m_valid = (count != '0);
  assign xfer    = m_valid && m_ready;
  assign m_data  = m_valid ? skid[head] : '0;
  assign m_last  = m_valid && (beat == BEAT_LAST);
  assign busy    = (state != IDLE);

  // A head beat leaving this cycle frees its slot, which lets a 2-entry skid sustain one byte per cycle.
  assign load    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(xfer);
  assign read_en = (state == RUN) && !fifo_empty && (load < (CW+1)'(SKID_DEPTH));

  always_ff @(posedge clock) begin
    if (inflight) begin
      skid[tail] <= fifo_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      beat     <= '0;
      rd_count <= '0;
    end else begin
      inflight <= read_en;
      if (inflight) begin
        tail <= ptr_next(tail);
      end
      if (xfer) begin
        head     <= ptr_next(head);
        beat     <= (beat == BEAT_LAST) ? '0 : beat + BW'(1);
        rd_count <= rd_count + 16'd1;
      end
      case ({inflight, xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (!inflight && (count == '0)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed bench for fifo_reader with a behavioural 16-deep FIFO and a beat log
module tb_fifo_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       read_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       busy;
  logic [15:0] rd_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fmem [16];
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  bit  fifo_flush = 1'b0;
  int  acc_n = 0;
  int  log_n = 0;
  int  cyc = 0;
  logic [7:0] log_d [128];
  logic       log_l [128];
  int         log_c [128];

  fifo_reader dut (
    .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .read_en(read_en), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .rd_count(rd_count)
  );

  always #5 clock = ~clock;

  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (fifo_flush) begin
      rd_cnt <= wr_cnt;
    end else if (read_en && !fifo_empty) begin
      fifo_data <= fmem[rd_cnt % 16];
      rd_cnt    <= rd_cnt + 1;
      acc_n     <= acc_n + 1;
    end
    if (m_valid && m_ready) begin
      log_d[log_n % 128] <= m_data;
      log_l[log_n % 128] <= m_last;
      log_c[log_n % 128] <= cyc;
      log_n <= log_n + 1;
    end
  end

  task automatic load_fifo(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_cnt % 16] = 8'(first + i);
      wr_cnt = wr_cnt + 1;
    end
  endtask

  task automatic wait_log(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (log_n >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++; if (read_en !== 1'b0) begin n_bad++; $display("FAIL rst_read_en: got %0b want 0", read_en); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_m_last: got %0b want 0", m_last); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rst_m_data: got %0h want 0", m_data); end
    n_cmp++; if (rd_count !== 16'd0) begin n_bad++; $display("FAIL rst_rd_count: got %0d want 0", rd_count); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_stream;
    int base;
    bit ok;
    base = log_n;
    load_fifo(8'h10, 8);
    m_ready = 1'b1;
    @(negedge clock);
    enable = 1'b1;
    wait_log(base + 8, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stream_timeout: got %0d beats want 8", log_n - base); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (log_d[(base+i) % 128] !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL stream_data[%0d]: got %0h want %0h", i, log_d[(base+i) % 128], 8'(8'h10 + i)); end
      n_cmp++; if (log_l[(base+i) % 128] !== ((i == 3) || (i == 7))) begin n_bad++; $display("FAIL stream_last[%0d]: got %0b want %0b", i, log_l[(base+i) % 128], (i == 3) || (i == 7)); end
    end
    for (int i = 1; i < 8; i++) begin
      n_cmp++; if (log_c[(base+i) % 128] !== log_c[(base+i-1) % 128] + 1) begin n_bad++; $display("FAIL stream_gap[%0d]: got cycle %0d want %0d", i, log_c[(base+i) % 128], log_c[(base+i-1) % 128] + 1); end
    end
    n_cmp++; if (rd_count !== 16'd8) begin n_bad++; $display("FAIL stream_rd_count: got %0d want 8", rd_count); end
    enable = 1'b0;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stream_idle: got busy %0b want 0", busy); end
  endtask

  task automatic test_backpressure;
    int base;
    bit ok;
    base = log_n;
    load_fifo(8'h10, 8);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (k >= 4 && k <= 7) begin
        n_cmp++; if (read_en !== 1'b0) begin n_bad++; $display("FAIL bp_read_en[k%0d]: got %0b want 0", k, read_en); end
        n_cmp++; if (m_data !== 8'h10) begin n_bad++; $display("FAIL bp_hold[k%0d]: got %0h want 10", k, m_data); end
      end
      if (k == 0) enable = 1'b1;
      m_ready = !(k >= 3 && k <= 7);
    end
    wait_log(base + 8, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: got %0d beats want 8", log_n - base); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (log_d[(base+i) % 128] !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL bp_data[%0d]: got %0h want %0h", i, log_d[(base+i) % 128], 8'(8'h10 + i)); end
      n_cmp++; if (log_l[(base+i) % 128] !== ((i == 3) || (i == 7))) begin n_bad++; $display("FAIL bp_last[%0d]: got %0b want %0b", i, log_l[(base+i) % 128], (i == 3) || (i == 7)); end
    end
    repeat (3) @(negedge clock);
    n_cmp++; if (log_n - base !== 8) begin n_bad++; $display("FAIL bp_count: got %0d beats want 8", log_n - base); end
    n_cmp++; if (rd_count !== 16'd16) begin n_bad++; $display("FAIL bp_rd_count: got %0d want 16", rd_count); end
    enable = 1'b0;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_idle: got busy %0b want 0", busy); end
  endtask

  task automatic test_empty;
    int base;
    int acc0;
    bit ok;
    base = log_n;
    acc0 = acc_n;
    m_ready = 1'b1;
    @(negedge clock);
    enable = 1'b1;
    repeat (4) @(negedge clock);
    n_cmp++; if (read_en !== 1'b0) begin n_bad++; $display("FAIL empty_read_en: got %0b want 0", read_en); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL empty_m_valid: got %0b want 0", m_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL empty_busy: got %0b want 1", busy); end
    load_fifo(8'hA5, 1);
    wait_log(base + 1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL empty_timeout: got %0d beats want 1", log_n - base); end
    n_cmp++; if (log_d[base % 128] !== 8'hA5) begin n_bad++; $display("FAIL empty_data: got %0h want a5", log_d[base % 128]); end
    n_cmp++; if (log_l[base % 128] !== 1'b0) begin n_bad++; $display("FAIL empty_last: got %0b want 0", log_l[base % 128]); end
    repeat (4) @(negedge clock);
    n_cmp++; if (acc_n - acc0 !== 1) begin n_bad++; $display("FAIL empty_reads: got %0d want 1", acc_n - acc0); end
    n_cmp++; if (log_n - base !== 1) begin n_bad++; $display("FAIL empty_beats: got %0d want 1", log_n - base); end
    n_cmp++; if (rd_count !== 16'd17) begin n_bad++; $display("FAIL empty_rd_count: got %0d want 17", rd_count); end
    enable = 1'b0;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL empty_idle: got busy %0b want 0", busy); end
  endtask

  task automatic test_stop;
    int base;
    int acc0;
    bit ok;
    bit dropped;
    base = log_n;
    acc0 = acc_n;
    dropped = 1'b0;
    load_fifo(8'h30, 8);
    @(negedge clock);
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if ((acc_n - acc0 == 2) && read_en) begin
        enable = 1'b0;
        dropped = 1'b1;
        break;
      end
    end
    n_cmp++; if (dropped !== 1'b1) begin n_bad++; $display("FAIL stop_reach: got %0d reads want 2", acc_n - acc0); end
    @(negedge clock);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stop_drain_busy: got %0b want 1", busy); end
    n_cmp++; if (read_en !== 1'b0) begin n_bad++; $display("FAIL stop_drain_read: got %0b want 0", read_en); end
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stop_idle: got busy %0b want 0", busy); end
    n_cmp++; if (acc_n - acc0 !== 3) begin n_bad++; $display("FAIL stop_reads: got %0d want 3", acc_n - acc0); end
    n_cmp++; if (log_n - base !== 3) begin n_bad++; $display("FAIL stop_beats: got %0d want 3", log_n - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (log_d[(base+i) % 128] !== 8'(8'h30 + i)) begin n_bad++; $display("FAIL stop_data[%0d]: got %0h want %0h", i, log_d[(base+i) % 128], 8'(8'h30 + i)); end
    end
    n_cmp++; if (wr_cnt - rd_cnt !== 5) begin n_bad++; $display("FAIL stop_fifo_left: got %0d want 5", wr_cnt - rd_cnt); end
    n_cmp++; if (rd_count !== 16'd20) begin n_bad++; $display("FAIL stop_rd_count: got %0d want 20", rd_count); end
  endtask

  task automatic test_reset_mid;
    int base;
    bit ok;
    bit reached;
    reached = 1'b0;
    @(negedge clock);
    fifo_flush = 1'b1;
    @(negedge clock);
    fifo_flush = 1'b0;
    base = log_n;
    load_fifo(8'h10, 8);
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (log_n - base == 3) begin
        reached = 1'b1;
        break;
      end
    end
    n_cmp++; if (reached !== 1'b1) begin n_bad++; $display("FAIL rmid_reach: got %0d beats want 3", log_n - base); end
    n_cmp++; if (log_d[(base+2) % 128] !== 8'h12) begin n_bad++; $display("FAIL rmid_beat2: got %0h want 12", log_d[(base+2) % 128]); end
    reset = 1'b1;
    #1;
    n_cmp++; if (read_en !== 1'b0) begin n_bad++; $display("FAIL rmid_read_en: got %0b want 0", read_en); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_m_valid: got %0b want 0", m_valid); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rmid_m_last: got %0b want 0", m_last); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rmid_m_data: got %0h want 0", m_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    n_cmp++; if (rd_count !== 16'd0) begin n_bad++; $display("FAIL rmid_rd_count: got %0d want 0", rd_count); end
    enable = 1'b0;
    @(negedge clock);
    fifo_flush = 1'b1;
    @(negedge clock);
    fifo_flush = 1'b0;
    reset = 1'b0;
    base = log_n;
    load_fifo(8'h20, 4);
    @(negedge clock);
    enable = 1'b1;
    wait_log(base + 4, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rmid_timeout: got %0d beats want 4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (log_d[(base+i) % 128] !== 8'(8'h20 + i)) begin n_bad++; $display("FAIL rmid_data[%0d]: got %0h want %0h", i, log_d[(base+i) % 128], 8'(8'h20 + i)); end
      n_cmp++; if (log_l[(base+i) % 128] !== (i == 3)) begin n_bad++; $display("FAIL rmid_last[%0d]: got %0b want %0b", i, log_l[(base+i) % 128], i == 3); end
    end
    n_cmp++; if (rd_count !== 16'd4) begin n_bad++; $display("FAIL rmid_rd_count: got %0d want 4", rd_count); end
    enable = 1'b0;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rmid_idle: got busy %0b want 0", busy); end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish within 200000 time units");
    $fatal(1);
  end

endmodule
